mem_access_controller: RTL and testbench
========================================

# mem_access_controller

Multi-cycle load/store engine between the control unit and the data-memory bus. It accepts one load or store request at a time and drives a registered request/acknowledge memory bus. For loads it extracts and zero-extends the addressed byte or word into the value that feeds the write-back `mem_in` path. It also flags misaligned word accesses and bus timeouts, so the control unit can hold `mem_wr` until `done`.

## Interface
Parameters:
- `WORD_SIZE`, 16, data width; must be 16.
- `ADDR_SIZE`, 16, byte-address width.
- `TIMEOUT`, 15, maximum bus-wait cycles before the access is aborted; range 1–255.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req` in 1: start an access; sampled only in IDLE.
- `we` in 1: 1 = store, 0 = load.
- `byte_mode` in 1: 1 = byte access, 0 = word access.
- `addr` in ADDR_SIZE: byte address.
- `wdata` in WORD_SIZE: store data; byte stores use `[7:0]`.
- `busy` out 1: access in progress; high in every state except IDLE.
- `done` out 1: one-cycle pulse on successful completion.
- `err` out 1: one-cycle pulse on misalign or timeout.
- `rdata_out` out WORD_SIZE: formatted load data; holds until the next load completes.
- `bus_addr` out ADDR_SIZE: word-aligned bus address, `{addr[ADDR_SIZE-1:1],1'b0}`.
- `bus_wdata` out WORD_SIZE: bus write data.
- `bus_be` out 2: byte enables; `[0]` = low byte (even address).
- `bus_rd`, `bus_wr` out 1: bus read or write strobe.
- `bus_rdata` in WORD_SIZE: bus read data.
- `bus_ack` in 1: bus completion; valid only while a strobe is high.

## Operation
- **Endianness:** little-endian. `addr[0]=0` selects the low byte, `addr[0]=1` selects the high byte.
- **Byte load:** `rdata_out = {8'h00, selected byte of bus_rdata}`.
- **Word load:** `rdata_out = bus_rdata`.
- **Byte store:** `bus_wdata = {wdata[7:0], wdata[7:0]}`; `bus_be = addr[0] ? 2'b10 : 2'b01`.
- **Word store / word load:** `bus_be = 2'b11`.
- **Misaligned access:** a word access with `addr[0]=1` starts no bus cycle. The request goes to ERROR.

FSM states:
- **IDLE**
  - On `req`: latch `we`, `byte_mode`, `addr`, `wdata`.
  - If misaligned, go to ERROR. Otherwise go to WAIT, asserting the bus strobe and bus fields.
  - Clear the wait counter.
- **WAIT**
  - Hold the strobe, `bus_addr`, `bus_be` and `bus_wdata` stable.
  - On `bus_ack`: capture the formatted load data (loads only) and go to DONE.
  - Else, if the wait counter equals `TIMEOUT-1`, go to ERROR.
  - Else increment the counter.
- **DONE:** `done=1` for this cycle; return to IDLE. Strobes are low.
- **ERROR:** `err=1` for this cycle; return to IDLE. `rdata_out` is unchanged. Strobes are low.

Boundary behaviour:
- `req` is ignored while `busy`; requests are not queued.
- `bus_ack` outside WAIT is ignored.
- `bus_ack` on the same cycle the counter reaches `TIMEOUT-1` counts as success; ack wins over timeout.
- A store never modifies `rdata_out`.
- `rst` in any state returns to IDLE on the next edge and drops strobes immediately; any in-flight bus cycle is abandoned.

## Timing
- **Reset values:** state IDLE; `busy`, `done`, `err`, `bus_rd`, `bus_wr` = 0; `bus_addr`, `bus_wdata`, `rdata_out`, wait counter = 0; `bus_be = 2'b00`.
- **Outputs:** all are registered; no combinational path from `bus_ack` or `bus_rdata` to any output.
- **Bus cycle:** `req` is sampled at edge 0. Strobe and `busy` are high from cycle 1. If `bus_ack` is high in cycle k (k≥1), the strobe drops and `done` and `rdata_out` are valid in cycle k+1. Minimum request-to-`done` latency is 2 cycles.
- **Timeout:** with no ack, the strobe is high for exactly `TIMEOUT` cycles (cycles 1..TIMEOUT). `err` pulses in cycle TIMEOUT+1.
- **Misalign:** `err` pulses in cycle 1; no strobe is ever asserted.
- **Back-to-back:** `busy` is low in the cycle after DONE or ERROR, so the next `req` can be accepted there. Throughput is at most one access per 3 cycles.

## Structure
- **Shared package `xm_mem_pkg`:**
  - `mem_state_t` enum (IDLE, WAIT, DONE, ERROR).
  - Byte-enable constants `BE_LO`, `BE_HI`, `BE_WORD`.
  - Function `fmt_load(rdata, byte_mode, a0)` for load formatting.
- **Sub-module:** one, `mem_wait_timer` — loadable counter with clear/enable inputs and a terminal-count output at `TIMEOUT-1`. Everything else stays in the top FSM.

## Test plan
- **Word load, 0 wait states:** `req`, `we=0`, `byte_mode=0`, `addr=16'h0040`; ack in cycle 1 with `bus_rdata=16'hBEEF` → `bus_addr=16'h0040`, `bus_be=2'b11`, `done` in cycle 2, `rdata_out=16'hBEEF`.
- **Byte loads:** `addr=16'h0041`, `bus_rdata=16'h12AB` → `rdata_out=16'h0012`. Repeat with `addr=16'h0040` → `16'h00AB`.
- **Byte store:** `addr=16'h0103`, `wdata=16'hFF5A`; ack after 3 wait cycles → `bus_addr=16'h0102`, `bus_wdata=16'h5A5A`, `bus_be=2'b10`. Strobe stable for 4 cycles. `rdata_out` is unchanged.
- **Misaligned word store:** `addr=16'h0011` → `err` in cycle 1; `bus_wr` never rises.
- **Timeout:** `TIMEOUT=4`, no ack → `bus_rd` high for cycles 1–4, `err` in cycle 5. Repeat with ack in cycle 4 → `done` in cycle 5, no `err`.
- **Reset and ignored inputs:** assert `rst` during WAIT → next cycle IDLE, all strobes low. `req` pulsed while `busy` is ignored. Stray `bus_ack` in IDLE produces no `done`.

Source files
------------

// File: rtl/xm_mem_pkg.sv
// Shared types and helpers for the data-memory load/store engine.
// Holds the FSM state encoding, byte-enable patterns and load-data formatting.
package xm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } mem_state_t;

  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_WORD = 2'b11;

  // Wide enough for the largest supported TIMEOUT (255).
  localparam int CNT_W = 8;

  // Little-endian byte select with zero extension; word loads pass through.
  function automatic logic [15:0] fmt_load(input logic [15:0] rdata,
                                           input logic        byte_mode,
                                           input logic        a0);
    logic [15:0] res;
    if (byte_mode) begin
      if (a0) begin
        res = {8'h00, rdata[15:8]};
      end else begin
        res = {8'h00, rdata[7:0]};
      end
    end else begin
      res = rdata;
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Bus-wait counter: cleared while idle, advanced per unacknowledged wait cycle,
// with a terminal-count flag at TIMEOUT-1.
module mem_wait_timer
  import xm_mem_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_r;

  // Wait-cycle counter with clear priority over enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (en) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign tc = (cnt_r == TC_VAL);

endmodule

// File: rtl/mem_access_controller.sv
// Multi-cycle load/store engine driving a registered req/ack data-memory bus.
// All outputs are registered; bus_ack/bus_rdata only reach outputs through flops.
module mem_access_controller
  import xm_mem_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 16,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic                 we,
  input  logic                 byte_mode,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [WORD_SIZE-1:0] wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [WORD_SIZE-1:0] rdata_out,
  output logic [ADDR_SIZE-1:0] bus_addr,
  output logic [WORD_SIZE-1:0] bus_wdata,
  output logic [1:0]           bus_be,
  output logic                 bus_rd,
  output logic                 bus_wr,
  input  logic [WORD_SIZE-1:0] bus_rdata,
  input  logic                 bus_ack
);

  mem_state_t           state_r, next_state_s;
  logic                 we_r, byte_r, a0_r;
  logic                 busy_r, done_r, err_r, bus_rd_r, bus_wr_r;
  logic [WORD_SIZE-1:0] rdata_r, bus_wdata_r;
  logic [ADDR_SIZE-1:0] bus_addr_r;
  logic [1:0]           bus_be_r;
  logic                 misaligned_s, start_s, req_we_s;
  logic                 timer_clr_s, timer_en_s, tc_s;

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (timer_clr_s),
    .en  (timer_en_s),
    .tc  (tc_s)
  );

  // Next-state and timer control; ack wins over terminal count.
  always_comb begin
    next_state_s = state_r;
    timer_clr_s  = 1'b0;
    timer_en_s   = 1'b0;
    misaligned_s = !byte_mode && addr[0];
    case (state_r)
      IDLE: begin
        timer_clr_s = 1'b1;
        if (req) begin
          if (misaligned_s) begin
            next_state_s = ERROR;
          end else begin
            next_state_s = WAIT;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      WAIT: begin
        if (bus_ack) begin
          next_state_s = DONE;
        end else if (tc_s) begin
          next_state_s = ERROR;
        end else begin
          next_state_s = WAIT;
          timer_en_s   = 1'b1;
        end
      end
      DONE:    next_state_s = IDLE;
      ERROR:   next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  assign start_s  = (state_r == IDLE) && (next_state_s == WAIT);
  assign req_we_s = start_s ? we : we_r;

  // State, request latch and registered bus/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      we_r        <= 1'b0;
      byte_r      <= 1'b0;
      a0_r        <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      bus_rd_r    <= 1'b0;
      bus_wr_r    <= 1'b0;
      bus_addr_r  <= {ADDR_SIZE{1'b0}};
      bus_wdata_r <= {WORD_SIZE{1'b0}};
      bus_be_r    <= 2'b00;
      rdata_r     <= {WORD_SIZE{1'b0}};
    end else begin
      state_r  <= next_state_s;
      busy_r   <= (next_state_s != IDLE);
      done_r   <= (next_state_s == DONE);
      err_r    <= (next_state_s == ERROR);
      bus_rd_r <= (next_state_s == WAIT) && !req_we_s;
      bus_wr_r <= (next_state_s == WAIT) && req_we_s;
      if ((state_r == IDLE) && req) begin
        we_r   <= we;
        byte_r <= byte_mode;
        a0_r   <= addr[0];
      end
      if (start_s) begin
        bus_addr_r  <= {addr[ADDR_SIZE-1:1], 1'b0};
        bus_wdata_r <= byte_mode ? {wdata[7:0], wdata[7:0]} : wdata;
        bus_be_r    <= byte_mode ? (addr[0] ? BE_HI : BE_LO) : BE_WORD;
      end
      // Stores and failed accesses leave the last load value in place.
      if ((state_r == WAIT) && bus_ack && !we_r) begin
        rdata_r <= fmt_load(bus_rdata, byte_r, a0_r);
      end
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;
  assign bus_rd    = bus_rd_r;
  assign bus_wr    = bus_wr_r;
  assign bus_addr  = bus_addr_r;
  assign bus_wdata = bus_wdata_r;
  assign bus_be    = bus_be_r;
  assign rdata_out = rdata_r;

endmodule

// File: tb/tb_mem_access_controller.sv
// Scoreboard bench for mem_access_controller with TIMEOUT=4: expected outcomes
// are queued at request time and checked when done/err appears.
module tb_mem_access_controller;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst, req, we, byte_mode, bus_ack;
  logic [15:0] addr, wdata, bus_rdata;
  logic        busy, done, err, bus_rd, bus_wr;
  logic [15:0] rdata_out, bus_addr, bus_wdata;
  logic [1:0]  bus_be;

  int checks = 0;
  int errors = 0;
  logic [15:0] model_rdata = 16'h0000;

  typedef struct {
    logic        is_err;
    logic [15:0] rdata;
    int          cycle;
    int          strobes;
  } exp_t;
  exp_t sb_q[$];

  mem_access_controller #(.WORD_SIZE(16), .ADDR_SIZE(16), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .byte_mode(byte_mode),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
    .rdata_out(rdata_out), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_rd(bus_rd), .bus_wr(bus_wr),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One access: queue the expectation, drive req, play the bus, check outcome.
  task automatic run_access(input logic w, input logic bm, input logic [15:0] a,
                            input logic [15:0] wd, input int ack_cyc,
                            input logic [15:0] rd, input int stray_cyc,
                            input string name);
    exp_t        e;
    logic [1:0]  ebe;
    logic [15:0] ewd;
    int          cyc;
    int          strobes;
    bit          fin;
    ebe = bm ? (a[0] ? 2'b10 : 2'b01) : 2'b11;
    ewd = bm ? {wd[7:0], wd[7:0]} : wd;
    if (!bm && a[0]) begin
      e.is_err = 1'b1; e.cycle = 1; e.strobes = 0;
    end else if (ack_cyc >= 1 && ack_cyc <= TO) begin
      e.is_err = 1'b0; e.cycle = ack_cyc + 1; e.strobes = ack_cyc;
      if (!w) model_rdata = bm ? ((rd >> (a[0] ? 8 : 0)) & 16'h00FF) : rd;
    end else begin
      e.is_err = 1'b1; e.cycle = TO + 1; e.strobes = TO;
    end
    e.rdata = model_rdata;
    sb_q.push_back(e);

    req = 1'b1; we = w; byte_mode = bm; addr = a; wdata = wd;
    tick;
    req = 1'b0;
    strobes = 0; fin = 1'b0; cyc = 1;
    while (!fin && cyc <= 40) begin
      if (done || err) begin
        fin = 1'b1;
      end else begin
        if (bus_rd || bus_wr) begin
          strobes++;
          checks++;
          if ({bus_rd, bus_wr} !== {!w, w} || bus_addr !== {a[15:1], 1'b0} ||
              bus_be !== ebe || (w && bus_wdata !== ewd) || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s bus cyc%0d: rd/wr=%b%b addr=%h be=%b wdata=%h busy=%b want rd/wr=%b%b addr=%h be=%b wdata=%h busy=1",
                     name, cyc, bus_rd, bus_wr, bus_addr, bus_be, bus_wdata, busy,
                     !w, w, {a[15:1], 1'b0}, ebe, ewd);
          end
        end
        if (cyc == ack_cyc) begin bus_ack = 1'b1; bus_rdata = rd; end
        if (cyc == stray_cyc) begin req = 1'b1; we = 1'b1; byte_mode = 1'b0; addr = 16'h0200; end
        tick;
        bus_ack = 1'b0; bus_rdata = 16'($urandom); req = 1'b0;
        cyc++;
      end
    end

    e = sb_q.pop_front();
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL %s end: no done/err within 40 cycles, want %s in cycle %0d",
               name, e.is_err ? "err" : "done", e.cycle);
    end else begin
      if ({err, done} !== {e.is_err, !e.is_err} || cyc != e.cycle) begin
        errors++;
        $display("FAIL %s end: err/done=%b%b at cycle %0d, want %b%b at cycle %0d",
                 name, err, done, cyc, e.is_err, !e.is_err, e.cycle);
      end
      checks++;
      if (strobes != e.strobes || rdata_out !== e.rdata) begin
        errors++;
        $display("FAIL %s data: strobe cycles=%0d rdata_out=%h, want %0d and %h",
                 name, strobes, rdata_out, e.strobes, e.rdata);
      end
      checks++;
      if ({bus_rd, bus_wr, busy} !== 3'b001) begin
        errors++;
        $display("FAIL %s final: rd/wr/busy=%b, want 001", name, {bus_rd, bus_wr, busy});
      end
    end
    tick;
    checks++;
    if ({busy, done, err} !== 3'b000) begin
      errors++;
      $display("FAIL %s idle: busy/done/err=%b, want 000", name, {busy, done, err});
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 1'b0; we = 1'b0; byte_mode = 1'b0; addr = 16'h0000;
    wdata = 16'h0000; bus_ack = 1'b0; bus_rdata = 16'h0000;
    tick; tick;
    checks++;
    if ({busy, done, err, bus_rd, bus_wr, bus_be, bus_addr, bus_wdata, rdata_out} !== 55'd0) begin
      errors++;
      $display("FAIL reset: busy/done/err/rd/wr=%b be=%b addr=%h wdata=%h rdata=%h, want all zero",
               {busy, done, err, bus_rd, bus_wr}, bus_be, bus_addr, bus_wdata, rdata_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_loads;
    run_access(1'b0, 1'b0, 16'h0040, 16'h0000, 1, 16'hBEEF, 0, "word_load");
    run_access(1'b0, 1'b1, 16'h0041, 16'h0000, 2, 16'h12AB, 0, "byte_load_hi");
    run_access(1'b0, 1'b1, 16'h0040, 16'h0000, 1, 16'h12AB, 0, "byte_load_lo");
  endtask

  task automatic test_stores;
    run_access(1'b1, 1'b1, 16'h0103, 16'hFF5A, 4, 16'h7777, 0, "byte_store");
    run_access(1'b1, 1'b0, 16'h0070, 16'hA5C3, 2, 16'h1111, 0, "word_store");
  endtask

  task automatic test_misaligned;
    run_access(1'b1, 1'b0, 16'h0011, 16'h1234, 0, 16'h0000, 0, "misalign_store");
    run_access(1'b0, 1'b0, 16'h0021, 16'h0000, 1, 16'h4321, 0, "misalign_load");
  endtask

  task automatic test_timeout;
    run_access(1'b0, 1'b0, 16'h0060, 16'h0000, 0, 16'h0000, 0, "timeout");
    run_access(1'b0, 1'b0, 16'h0062, 16'h0000, TO, 16'hC0DE, 0, "ack_at_limit");
  endtask

  task automatic test_back_to_back;
    run_access(1'b0, 1'b1, 16'h0301, 16'h0000, 1, 16'h9A55, 0, "b2b_1");
    run_access(1'b1, 1'b1, 16'h0300, 16'h00C3, 1, 16'h0000, 0, "b2b_2");
    run_access(1'b0, 1'b0, 16'h0302, 16'h0000, 3, 16'h6E2D, 0, "b2b_3");
  endtask

  task automatic test_ignored;
    run_access(1'b0, 1'b0, 16'h0090, 16'h0000, 3, 16'h1357, 2, "stray_req");
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({busy, bus_wr, bus_rd} !== 3'b000) begin
        errors++;
        $display("FAIL stray_req after: busy/wr/rd=%b, want 000", {busy, bus_wr, bus_rd});
      end
      tick;
    end
    bus_ack = 1'b1; bus_rdata = 16'hFFFF;
    tick; tick;
    checks++;
    if ({done, err, busy} !== 3'b000 || rdata_out !== model_rdata) begin
      errors++;
      $display("FAIL stray_ack: done/err/busy=%b rdata=%h, want 000 and %h",
               {done, err, busy}, rdata_out, model_rdata);
    end
    bus_ack = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid;
    req = 1'b1; we = 1'b0; byte_mode = 1'b0; addr = 16'h0080;
    tick;
    req = 1'b0;
    checks++;
    if ({bus_rd, busy} !== 2'b11) begin
      errors++;
      $display("FAIL rst_mid start: rd/busy=%b, want 11", {bus_rd, busy});
    end
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    model_rdata = 16'h0000;
    checks++;
    if ({bus_rd, bus_wr, busy, done, err} !== 5'b00000 || rdata_out !== model_rdata) begin
      errors++;
      $display("FAIL rst_mid: rd/wr/busy/done/err=%b rdata=%h, want 00000 and 0000",
               {bus_rd, bus_wr, busy, done, err}, rdata_out);
    end
    bus_ack = 1'b1;
    tick;
    bus_ack = 1'b0;
    checks++;
    if ({bus_rd, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid after: rd/busy/done=%b, want 000", {bus_rd, busy, done});
    end
  endtask

  initial begin
    test_reset;
    test_loads;
    test_stores;
    test_misaligned;
    test_timeout;
    test_back_to_back;
    test_ignored;
    test_reset_mid;
    run_access(1'b0, 1'b0, 16'h00A0, 16'h0000, 2, 16'h2468, 0, "post_reset_load");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
